// File: rtl/alu_pkg.sv
// Shared types and helpers for the alu_v3 datapath.
// Build option: define ALU_V3_SAT_EN to clamp overflowed results instead of wrapping.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_MUL  = 3'd2,
        OP_MAC  = 3'd3,
        OP_CLR  = 3'd4,
        OP_LDI  = 3'd5,
        OP_LDSW = 3'd6,
        OP_ACC  = 3'd7
    } alu_op_t;

    // Widest supported operand; exact intermediates live in WIDE bits.
    localparam int MAXW = 32;
    localparam int WIDE = 2 * MAXW + 1;

    typedef logic signed [WIDE-1:0] wide_t;

    // Narrow an exact value to w bits. Returns {ovf, value[MAXW-1:0]};
    // the caller keeps the low w bits of the value field.
    function automatic logic [MAXW:0] sat_narrow(input wide_t v, input int w);
        wide_t             hi;
        wide_t             lo;
        logic              o;
        logic [MAXW-1:0]   r;
        hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
        lo = -(wide_t'(1) <<< (w - 1));
        o  = (v > hi) || (v < lo);
`ifdef ALU_V3_SAT_EN
        if (v > hi)
            r = hi[MAXW-1:0];
        else if (v < lo)
            r = lo[MAXW-1:0];
        else
            r = v[MAXW-1:0];
`else
        r = v[MAXW-1:0];
`endif
        return {o, r};
    endfunction

endpackage

// File: rtl/alu_v3_mult.sv
// Combinational signed WIDTH x WIDTH multiplier, result arithmetic-shifted right by FRAC.
module alu_v3_mult #(
    parameter int WIDTH = 8,
    parameter int FRAC  = 0
) (
    input  logic signed [WIDTH-1:0]   i_a,
    input  logic signed [WIDTH-1:0]   i_b,
    output logic signed [2*WIDTH-1:0] o_prod
);

    logic signed [2*WIDTH-1:0] w_ax;
    logic signed [2*WIDTH-1:0] w_bx;
    logic signed [2*WIDTH-1:0] w_full;

    assign w_ax   = {{WIDTH{i_a[WIDTH-1]}}, i_a};
    assign w_bx   = {{WIDTH{i_b[WIDTH-1]}}, i_b};
    // The exact product always fits in 2*WIDTH bits, so the low half of the
    // wider multiply is exact.
    assign w_full = w_ax * w_bx;
    assign o_prod = w_full >>> FRAC;

endmodule

// File: rtl/alu_v3.sv
// Two-stage pipelined signed fixed-point ALU with accumulator and overflow flag.
// Build option: ALU_V3_SAT_EN selects saturating results (see alu_pkg::sat_narrow).
module alu_v3
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int FRAC  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  alu_op_t          op,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    input  logic [WIDTH-1:0] imm,
    input  logic [WIDTH-1:0] sw,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             ovf
);

    logic             r_s1_valid;
    alu_op_t          r_s1_op;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic [WIDTH-1:0] r_s1_ld;
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_ovf;
    logic [WIDTH-1:0] r_acc;

    logic                      w_s2_adv;
    logic                      w_accept;
    logic                      w_xfer;
    logic signed [2*WIDTH-1:0] w_prod;
    wide_t                     w_a;
    wide_t                     w_b;
    wide_t                     w_p;
    wide_t                     w_acc;
    wide_t                     w_wide;
    logic [MAXW:0]             w_nar;
    logic [WIDTH-1:0]          w_res;
    logic                      w_ovf;
    logic                      w_unused;

    assign w_s2_adv  = !r_s2_valid || out_ready;
    assign in_ready  = !r_s1_valid || w_s2_adv;
    assign w_accept  = in_valid && in_ready;
    assign w_xfer    = r_s1_valid && w_s2_adv;
    assign out_valid = r_s2_valid;
    assign result    = r_result;
    assign ovf       = r_ovf;

    alu_v3_mult #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mult (
        .i_a    (r_s1_a),
        .i_b    (r_s1_b),
        .o_prod (w_prod)
    );

    // Sign-extend everything to the package's wide type so each op yields its exact value.
    assign w_a   = {{(WIDE-WIDTH){r_s1_a[WIDTH-1]}}, r_s1_a};
    assign w_b   = {{(WIDE-WIDTH){r_s1_b[WIDTH-1]}}, r_s1_b};
    assign w_p   = {{(WIDE-2*WIDTH){w_prod[2*WIDTH-1]}}, w_prod};
    assign w_acc = {{(WIDE-WIDTH){r_acc[WIDTH-1]}}, r_acc};

    always_comb begin
        w_wide = '0;
        case (r_s1_op)
            OP_ADD:  w_wide = w_a + w_b;
            OP_SUB:  w_wide = w_a - w_b;
            OP_MUL:  w_wide = w_p;
            OP_MAC:  w_wide = w_acc + w_p;
            default: w_wide = '0;
        endcase
    end

    assign w_nar    = sat_narrow(w_wide, WIDTH);
    assign w_unused = ^w_nar[MAXW-1:WIDTH];

    always_comb begin
        w_res = w_nar[WIDTH-1:0];
        w_ovf = w_nar[MAXW];
        case (r_s1_op)
            OP_CLR: begin
                w_res = '0;
                w_ovf = 1'b0;
            end
            OP_LDI, OP_LDSW: begin
                w_res = r_s1_ld;
                w_ovf = 1'b0;
            end
            OP_ACC: begin
                w_res = r_acc;
                w_ovf = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= OP_ADD;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_ld    <= '0;
            r_s2_valid <= 1'b0;
            r_result   <= '0;
            r_ovf      <= 1'b0;
            r_acc      <= '0;
        end else begin
            if (w_accept) begin
                r_s1_op <= op;
                r_s1_a  <= data_a;
                r_s1_b  <= data_b;
                // Only one of imm/sw is ever needed, so pick it at acceptance.
                r_s1_ld <= (op == OP_LDSW) ? sw : imm;
            end
            if (w_accept)
                r_s1_valid <= 1'b1;
            else if (w_s2_adv)
                r_s1_valid <= 1'b0;
            if (w_s2_adv)
                r_s2_valid <= r_s1_valid;
            if (w_xfer) begin
                r_result <= w_res;
                r_ovf    <= w_ovf;
                if (r_s1_op == OP_MAC || r_s1_op == OP_CLR)
                    r_acc <= w_res;
            end
        end
    end

endmodule

// File: tb/tb_alu_v3.sv
// Directed self-checking bench for alu_v3: one Q8.0 instance and one Q4.4 instance on shared stimulus.
module tb_alu_v3;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    alu_op_t    op = OP_ADD;
    logic [7:0] data_a = '0;
    logic [7:0] data_b = '0;
    logic [7:0] imm = '0;
    logic [7:0] sw = '0;

    logic       in_ready, out_valid, ovf;
    logic [7:0] result;
    logic       in_ready4, out_valid4, ovf4;
    logic [7:0] result4;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef ALU_V3_SAT_EN
    localparam logic [7:0] E_ADD = 8'h7F;
    localparam logic [7:0] E_SUB = 8'h80;
    localparam logic [7:0] E_MUL = 8'h7F;
    localparam logic [7:0] E_BIG = 8'h7F;
`else
    localparam logic [7:0] E_ADD = 8'h96;
    localparam logic [7:0] E_SUB = 8'h7F;
    localparam logic [7:0] E_MUL = 8'h80;
    localparam logic [7:0] E_BIG = 8'h00;
`endif

    always #5 clk = ~clk;

    alu_v3 #(.WIDTH(8), .FRAC(0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .data_a(data_a), .data_b(data_b), .imm(imm), .sw(sw),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .ovf(ovf)
    );

    alu_v3 #(.WIDTH(8), .FRAC(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4), .op(op),
        .data_a(data_a), .data_b(data_b), .imm(imm), .sw(sw),
        .out_valid(out_valid4), .out_ready(out_ready), .result(result4), .ovf(ovf4)
    );

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input alu_op_t o, input logic [7:0] x, input logic [7:0] y,
                         input logic [7:0] i, input logic [7:0] s);
        in_valid = 1'b1;
        op       = o;
        data_a   = x;
        data_b   = y;
        imm      = i;
        sw       = s;
    endtask

    // Issue one op, then land just after the edge where its result becomes valid.
    task automatic single(input alu_op_t o, input logic [7:0] x, input logic [7:0] y,
                          input logic [7:0] i, input logic [7:0] s);
        drive(o, x, y, i, s);
        step();
        in_valid = 1'b0;
        step();
    endtask

    initial begin
        #12 rst_n = 1'b1;
        step();
        chk1("rst_in_ready", in_ready, 1'b1);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk8("rst_result", result, 8'h00);
        chk1("rst_ovf", ovf, 1'b0);

        single(OP_ADD, 8'd100, 8'd50, 8'h00, 8'h00);
        chk1("add_valid", out_valid, 1'b1);
        chk8("add_ovf_res", result, E_ADD);
        chk1("add_ovf", ovf, 1'b1);

        single(OP_SUB, 8'h80, 8'h01, 8'h00, 8'h00);
        chk8("sub_min_res", result, E_SUB);
        chk1("sub_min_ovf", ovf, 1'b1);

        single(OP_MUL, 8'hF8, 8'h10, 8'h00, 8'h00);
        chk8("mul_m8x16", result, 8'h80);
        chk1("mul_m8x16_ovf", ovf, 1'b0);
        chk8("q44_mul_m05x1", result4, 8'hF8);
        chk1("q44_mul_m05x1_ovf", ovf4, 1'b0);

        single(OP_MUL, 8'h80, 8'hFF, 8'h00, 8'h00);
        chk8("mul_m128xm1", result, E_MUL);
        chk1("mul_m128xm1_ovf", ovf, 1'b1);
        chk8("q44_mul_m8xm1", result4, 8'h08);

        single(OP_MUL, 8'h18, 8'h20, 8'h00, 8'h00);
        chk8("q44_mul_1p5x2", result4, 8'h30);
        chk1("q44_mul_1p5x2_ovf", ovf4, 1'b0);
        chk8("mul_24x32", result, E_BIG);
        chk1("mul_24x32_ovf", ovf, 1'b1);

        single(OP_MUL, 8'hFF, 8'h01, 8'h00, 8'h00);
        chk8("q44_mul_floor", result4, 8'hFF);
        chk8("mul_m1x1", result, 8'hFF);

        single(OP_LDI, 8'h00, 8'h00, 8'h7F, 8'h11);
        chk8("ldi", result, 8'h7F);
        chk1("ldi_ovf", ovf, 1'b0);
        single(OP_LDSW, 8'h00, 8'h00, 8'h22, 8'h80);
        chk8("ldsw", result, 8'h80);

        // MAC chain streamed back-to-back.
        drive(OP_CLR, 8'h00, 8'h00, 8'h00, 8'h00);
        step();
        drive(OP_MAC, 8'd3, 8'd4, 8'h00, 8'h00);
        step();
        chk8("chain_clr", result, 8'd0);
        drive(OP_MAC, 8'd5, 8'd6, 8'h00, 8'h00);
        step();
        chk8("chain_mac1", result, 8'd12);
        chk1("chain_mac1_valid", out_valid, 1'b1);
        drive(OP_ACC, 8'h00, 8'h00, 8'h00, 8'h00);
        step();
        in_valid = 1'b0;
        chk8("chain_mac2", result, 8'd42);
        step();
        chk8("chain_acc", result, 8'd42);
        chk1("chain_acc_ovf", ovf, 1'b0);
        step();
        chk1("chain_drained", out_valid, 1'b0);

        // Back-pressure: LDI 1,2,3 with out_ready low.
        out_ready = 1'b0;
        drive(OP_LDI, 8'h00, 8'h00, 8'd1, 8'h00);
        step();
        chk1("bp_ready_after1", in_ready, 1'b1);
        drive(OP_LDI, 8'h00, 8'h00, 8'd2, 8'h00);
        step();
        chk1("bp_valid", out_valid, 1'b1);
        chk8("bp_res1", result, 8'd1);
        chk1("bp_ready_drop", in_ready, 1'b0);
        drive(OP_LDI, 8'h00, 8'h00, 8'd3, 8'h00);
        step();
        chk8("bp_res1_hold", result, 8'd1);
        chk1("bp_ready_low", in_ready, 1'b0);
        out_ready = 1'b1;
        #1;
        chk1("bp_ready_comb", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        chk8("bp_res2", result, 8'd2);
        step();
        chk8("bp_res3", result, 8'd3);
        chk1("bp_res3_valid", out_valid, 1'b1);
        step();
        chk1("bp_drained", out_valid, 1'b0);

        // Reset with a MAC result parked at the output.
        drive(OP_CLR, 8'h00, 8'h00, 8'h00, 8'h00);
        step();
        drive(OP_MAC, 8'd10, 8'd10, 8'h00, 8'h00);
        step();
        in_valid = 1'b0;
        step();
        out_ready = 1'b0;
        chk8("rs_mac", result, 8'd100);
        chk1("rs_mac_valid", out_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk1("rs_async_valid", out_valid, 1'b0);
        chk8("rs_async_result", result, 8'h00);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step();
        chk1("rs_in_ready", in_ready, 1'b1);
        chk1("rs_out_valid", out_valid, 1'b0);
        single(OP_ACC, 8'h00, 8'h00, 8'h00, 8'h00);
        chk8("rs_acc_cleared", result, 8'h00);
        chk8("rs_acc_cleared_q44", result4, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
